// File: rtl/des_pkg.sv
// Shared DES S-box definitions: tables, lookup helper, LANES legality check and FSM states.
package des_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Bit n set means n S-boxes per cycle is a legal LANES value.
  localparam logic [8:0] LanesLegal = 9'b1_0001_0110;

  function automatic bit lanes_legal(input int unsigned n);
    return (n <= 32'd8) && LanesLegal[n[3:0]];
  endfunction

  // Each entry is one S-box, row-major (row 0 col 0 in the top nibble).
  localparam logic [255:0] SboxTab [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Row is {g[5],g[0]}, column is g[4:1]; entry index is row*16+col.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] grp);
    logic [5:0]   idx;
    logic [255:0] tab;
    idx = {grp[5], grp[0], grp[4:1]};
    tab = SboxTab[box];
    return tab[{~idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/des_sbox_sel.sv
// Combinational single S-box lookup with the box selected at run time.
module des_sbox_sel (
  input  logic [2:0] box,
  input  logic [5:0] grp,
  output logic [3:0] nib
);
  import des_pkg::*;

  assign nib = sbox_lookup(box, grp);

endmodule

// File: rtl/sbox_layer_seq.sv
// Sequential DES S-box layer: evaluates LANES S-boxes per cycle over 8/LANES RUN steps.
module sbox_layer_seq #(
  parameter int unsigned LANES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic        busy
);
  import des_pkg::*;

  localparam int unsigned Steps = (LANES == 0) ? 1 : 8 / LANES;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [CntW-1:0] LastStep = CntW'(Steps - 1);

  if (!lanes_legal(LANES)) begin : g_lanes_check
    $error("sbox_layer_seq: LANES must be 1, 2, 4 or 8");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [47:0]       din_q, din_d;
  logic [31:0]       acc_q, acc_d;
  logic              accept;

  logic [2:0]        box [LANES];
  logic [5:0]        grp [LANES];
  logic [3:0]        nib [LANES];

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StLoad) || (state_q == StRun);
  assign dout      = acc_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [47:0] aligned;
    assign box[l]  = 3'(int'(cnt_q) * LANES + l);
    // Shift the selected group up to the S1 position.
    assign aligned = din_q << (6'(box[l]) * 6'd6);
    assign grp[l]  = aligned[47:42];

    des_sbox_sel u_sel (
      .box (box[l]),
      .grp (grp[l]),
      .nib (nib[l])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: state_d = StIdle;
      StLoad: state_d = StRun;
      StRun: begin
        for (int l = 0; l < LANES; l++) begin
          acc_d[{~box[l], 2'b00} +: 4] = nib[l];
        end
        if (cnt_q == LastStep) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Accept overrides the Done->Idle exit so back-to-back words need no bubble.
    if (accept) begin
      din_d   = din;
      cnt_d   = '0;
      state_d = StLoad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      din_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Randomized self-checking bench for sbox_layer_seq against a table-driven DES S-box model.
module tb_sbox_layer_seq;

  localparam int unsigned MainLanes = 2;
  localparam int unsigned MainSteps = 8 / MainLanes;

  // Standard DES S1..S8, row-major, 16 hex digits per row.
  localparam logic [255:0] RefTab [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  sbox_layer_seq #(.LANES(MainLanes)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_sbox(input logic [47:0] x);
    logic [31:0]  r;
    logic [47:0]  sh;
    logic [255:0] t;
    int           g, row, col;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      sh  = x >> (42 - 6 * b);
      g   = int'(sh[5:0]);
      row = ((g >> 5) & 1) * 2 + (g & 1);
      col = (g >> 1) & 15;
      t   = RefTab[b] >> (4 * (63 - (row * 16 + col)));
      r   = {r[27:0], t[3:0]};
    end
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  // Present d (with out_ready=rdy) at a negedge, then measure latency to out_valid.
  task automatic xfer(input logic [47:0] d, input logic rdy, input string tag);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    din       = d;
    out_ready = rdy;
    #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!out_valid && n < 20);
    check({tag, "_latency"}, 64'(n), 64'(MainSteps + 1));
    check({tag, "_dout"}, 64'(dout), 64'(ref_sbox(d)));
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ov_low"}, 64'(out_valid), 64'd0);
  endtask

  // Extra instances for the other LANES values: reset state, latency and fixed/random patterns.
  for (genvar gi = 0; gi < 3; gi++) begin : g_aux
    localparam int unsigned L = (gi == 0) ? 1 : (gi == 1) ? 4 : 8;
    localparam int unsigned S = 8 / L;
    logic        rst_n_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [47:0] din_a;
    logic [31:0] dout_a;
    bit          done = 1'b0;

    sbox_layer_seq #(.LANES(L)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n_a),
      .in_valid  (in_valid_a),
      .in_ready  (in_ready_a),
      .din       (din_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready_a),
      .dout      (dout_a),
      .busy      (busy_a)
    );

    initial begin
      int          n;
      logic [47:0] pat;
      string       pfx;
      pfx         = $sformatf("L%0d", L);
      rst_n_a     = 1'b0;
      in_valid_a  = 1'b0;
      out_ready_a = 1'b0;
      din_a       = '0;
      repeat (3) @(negedge clk);
      rst_n_a = 1'b1;
      #1;
      check({pfx, "_rst_ov"}, 64'(out_valid_a), 64'd0);
      check({pfx, "_rst_ir"}, 64'(in_ready_a), 64'd1);
      check({pfx, "_rst_dout"}, 64'(dout_a), 64'd0);
      for (int p = 0; p < 4; p++) begin
        pat = (p == 0) ? 48'h0 : (p == 1) ? 48'hFFFF_FFFF_FFFF : rand48();
        if (p != 0) @(negedge clk);
        in_valid_a = 1'b1;
        din_a      = pat;
        @(posedge clk);
        #1 in_valid_a = 1'b0;
        n = 0;
        do begin
          @(posedge clk);
          n++;
          #1;
        end while (!out_valid_a && n < 20);
        check($sformatf("%s_p%0d_latency", pfx, p), 64'(n), 64'(S + 1));
        check($sformatf("%s_p%0d_dout", pfx, p), 64'(dout_a), 64'(ref_sbox(pat)));
        @(negedge clk);
        out_ready_a = 1'b1;
        @(posedge clk);
        #1 out_ready_a = 1'b0;
        check($sformatf("%s_p%0d_ov_low", pfx, p), 64'(out_valid_a), 64'd0);
      end
      done = 1'b1;
    end
  end

  initial begin
    logic [47:0] q[$];
    logic [47:0] cur, w;
    logic [31:0] dout_s;
    logic        acc, give, pend;
    int          accepted, delivered, cyc, wt;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    repeat (3) @(negedge clk);
    check("in_reset_ov", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_ir", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);

    xfer(48'h0, 1'b0, "zero");
    check("zero_known", 64'(dout), 64'h0000_0000_EFA7_2C4D);
    drain("zero");

    xfer(48'hFFFF_FFFF_FFFF, 1'b0, "ones");
    check("ones_known", 64'(dout), 64'h0000_0000_D9CE_3DCB);

    // Hold the consumer off for 5 cycles in Done.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_ov", i), 64'(out_valid), 64'd1);
      check($sformatf("stall%0d_dout", i), 64'(dout), 64'(ref_sbox(48'hFFFF_FFFF_FFFF)));
      check($sformatf("stall%0d_ir", i), 64'(in_ready), 64'd0);
    end

    xfer(rand48(), 1'b1, "b2b");
    drain("b2b");

    // Reset while in RUN step 1.
    w = rand48();
    @(negedge clk);
    in_valid = 1'b1;
    din      = w;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrun_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_ov", 64'(out_valid), 64'd0);
    check("midrun_rst_dout", 64'(dout), 64'd0);
    check("midrun_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrun_rel_ir", 64'(in_ready), 64'd1);
    xfer(rand48(), 1'b0, "after_rst");
    drain("after_rst");

    // Random traffic with back-pressure against a FIFO of expected results.
    accepted  = 0;
    delivered = 0;
    cyc       = 0;
    pend      = 1'b0;
    cur       = '0;
    while ((accepted < 1000 || q.size() > 0) && cyc < 40000) begin
      @(negedge clk);
      if (!pend) cur = rand48();
      din       = cur;
      in_valid  = pend || ((accepted < 1000) && ($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc    = in_valid && in_ready;
      give   = out_valid && out_ready;
      dout_s = dout;
      pend   = in_valid && !acc;
      @(posedge clk);
      if (give) begin
        delivered++;
        if (q.size() == 0) check("rnd_spurious_out", 64'(q.size()), 64'd1);
        else check("rnd_dout", 64'(dout_s), 64'(ref_sbox(q.pop_front())));
      end
      if (acc) begin
        q.push_back(cur);
        accepted++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rnd_delivered", 64'(delivered), 64'd1000);

    wt = 0;
    while (!(g_aux[0].done && g_aux[1].done && g_aux[2].done) && wt < 5000) begin
      @(posedge clk);
      wt++;
    end
    check("aux_done", 64'({g_aux[0].done, g_aux[1].done, g_aux[2].done}), 64'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
